// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser pattern generator.
//   LA_DW / LA_AW / LA_CW : default sample, address and repetition widths
//   la_state_e            : generator FSM state encoding
package la_pkg;

    localparam int LA_DW = 8;
    localparam int LA_AW = 14;
    localparam int LA_CW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } la_state_e;

endpackage

// File: rtl/la_gen_mem.sv
// Pattern memory: simple dual-port RAM, one write port and one synchronous
// read port with read enable. Contents are not reset.
//   clk            : clock
//   wen/wadr/wdat  : write port
//   ren/radr       : read request, data appears on rdat after the next edge
//   rdat           : registered read data, held while ren is low
module la_gen_mem #(
    parameter int DW = 8,
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdat,
    input  logic          ren,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rdat
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdat_q;

    // Read and write share one nonblocking block, so a same-address
    // collision returns the old contents (read-before-write).
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[wadr] <= wdat;
        end
        if (ren) begin
            rdat_q <= mem_q[radr];
        end
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/la_gen.sv
// Pattern generator: replays cfg_len+1 samples from pattern memory as an
// AXI-stream, cfg_rep times (0 = forever), optionally after a trigger.
//   clk, rst                  : clock, async active-high reset
//   ctl_rst/ctl_start/ctl_stop: abort, arm, graceful stop
//   trg, cfg_*                : trigger and configuration
//   mem_*                     : pattern memory write port
//   sts_run, sts_rep          : busy flag, completed repetitions
//   sto_*                     : output stream
//
// state | meaning
// IDLE  | waiting for ctl_start
// ARMED | waiting for trg
// RUN   | reading pattern memory, one read per advance cycle
// STOP  | no more reads, draining until the tlast sample is accepted
module la_gen
    import la_pkg::*;
#(
    parameter int DW = LA_DW,
    parameter int AW = LA_AW,
    parameter int CW = LA_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_rst,
    input  logic          ctl_start,
    input  logic          ctl_stop,
    input  logic          trg,
    input  logic          cfg_trg,
    input  logic [AW-1:0] cfg_len,
    input  logic [CW-1:0] cfg_rep,
    input  logic          mem_wen,
    input  logic [AW-1:0] mem_wadr,
    input  logic [DW-1:0] mem_wdat,
    output logic          sts_run,
    output logic [CW-1:0] sts_rep,
    output logic [DW-1:0] sto_tdata,
    output logic          sto_tkeep,
    output logic          sto_tlast,
    output logic          sto_tvalid,
    input  logic          sto_tready
);

    la_state_e     state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [CW-1:0] rep_q, rep_d;
    logic          pend_q, pend_d;      // ctl_stop seen, end at next wrap
    logic          s1_vld_q, s1_vld_d;  // memory read stage holds a sample
    logic          s1_lst_q, s1_lst_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic [DW-1:0] tdata_q, tdata_d;
    logic          run_q, run_d;

    logic          advance;
    logic          ren;
    logic          rd_lst;
    logic          at_end;
    logic          done;
    logic [CW:0]   rep_inc;
    logic [DW-1:0] mem_rdat;

    la_gen_mem #(.DW(DW), .AW(AW)) u_mem (
        .clk  (clk),
        .wen  (mem_wen),
        .wadr (mem_wadr),
        .wdat (mem_wdat),
        .ren  (ren),
        .radr (adr_q),
        .rdat (mem_rdat)
    );

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        rep_d    = rep_q;
        pend_d   = pend_q;
        s1_vld_d = s1_vld_q;
        s1_lst_d = s1_lst_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        ren      = 1'b0;
        rd_lst   = 1'b0;

        advance = !tvalid_q || sto_tready;
        at_end  = (adr_q == cfg_len);
        rep_inc = {1'b0, rep_q} + (CW+1)'(1);
        // The wrap being issued now completes the requested repetition count.
        done    = (cfg_rep != '0) && (rep_inc == {1'b0, cfg_rep});

        case (state_q)
            ST_IDLE: begin
                if (ctl_start) begin
                    rep_d   = '0;
                    adr_d   = '0;
                    pend_d  = 1'b0;
                    state_d = cfg_trg ? ST_ARMED : ST_RUN;
                end
            end
            ST_ARMED: begin
                if (trg) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ctl_stop) begin
                    pend_d = 1'b1;
                end
                if (advance) begin
                    ren = 1'b1;
                    if (at_end) begin
                        adr_d = '0;
                        rep_d = (&rep_q) ? rep_q : rep_inc[CW-1:0];
                        // Natural end and stop request can coincide: one tlast.
                        if (done || pend_q || ctl_stop) begin
                            rd_lst  = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        adr_d = adr_q + AW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tvalid_q && tlast_q && sto_tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            s1_vld_d = ren;
            s1_lst_d = rd_lst;
            tvalid_d = s1_vld_q;
            tlast_d  = s1_vld_q && s1_lst_q;
            if (s1_vld_q) begin
                tdata_d = mem_rdat;
            end
        end

        if (ctl_rst) begin
            state_d  = ST_IDLE;
            adr_d    = '0;
            rep_d    = '0;
            pend_d   = 1'b0;
            s1_vld_d = 1'b0;
            s1_lst_d = 1'b0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            ren      = 1'b0;
        end

        run_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            rep_q    <= '0;
            pend_q   <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_lst_q <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            rep_q    <= rep_d;
            pend_q   <= pend_d;
            s1_vld_q <= s1_vld_d;
            s1_lst_q <= s1_lst_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            run_q    <= run_d;
        end
    end

    assign sts_run    = run_q;
    assign sts_rep    = rep_q;
    assign sto_tdata  = tdata_q;
    assign sto_tkeep  = 1'b1;
    assign sto_tlast  = tlast_q;
    assign sto_tvalid = tvalid_q;

endmodule

// File: tb/tb_la_gen.sv
// Directed testbench for la_gen: finite run, backpressure, trigger, stop,
// coincident stop, single-sample period, abort and async reset.
module tb_la_gen;

    localparam int DW = 8;
    localparam int AW = 14;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctl_rst = 1'b0, ctl_start = 1'b0, ctl_stop = 1'b0;
    logic          trg = 1'b0, cfg_trg = 1'b0;
    logic [AW-1:0] cfg_len = AW'(3);
    logic [CW-1:0] cfg_rep = CW'(2);
    logic          mem_wen = 1'b0;
    logic [AW-1:0] mem_wadr = '0;
    logic [DW-1:0] mem_wdat = '0;
    logic          sts_run;
    logic [CW-1:0] sts_rep;
    logic [DW-1:0] sto_tdata;
    logic          sto_tkeep, sto_tlast, sto_tvalid;
    logic          sto_tready = 1'b1;

    la_gen #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ctl_rst    (ctl_rst),
        .ctl_start  (ctl_start),
        .ctl_stop   (ctl_stop),
        .trg        (trg),
        .cfg_trg    (cfg_trg),
        .cfg_len    (cfg_len),
        .cfg_rep    (cfg_rep),
        .mem_wen    (mem_wen),
        .mem_wadr   (mem_wadr),
        .mem_wdat   (mem_wdat),
        .sts_run    (sts_run),
        .sts_rep    (sts_rep),
        .sto_tdata  (sto_tdata),
        .sto_tkeep  (sto_tkeep),
        .sto_tlast  (sto_tlast),
        .sto_tvalid (sto_tvalid),
        .sto_tready (sto_tready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_unstable = 0;
    logic          stall_p = 1'b0;
    logic [DW-1:0] stall_d = '0;
    logic          stall_l = 1'b0;
    logic [DW-1:0] q_dat[$];
    logic          q_lst[$];
    logic [DW-1:0] pat [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check hold-while-stalled, record handshakes, advance.
    task tick();
        if (stall_p && (sto_tvalid !== 1'b1 || sto_tdata !== stall_d || sto_tlast !== stall_l))
            n_unstable++;
        if (sto_tvalid && sto_tready) begin
            q_dat.push_back(sto_tdata);
            q_lst.push_back(sto_tlast);
        end
        stall_p = sto_tvalid && !sto_tready && !ctl_rst && !rst;
        stall_d = sto_tdata;
        stall_l = sto_tlast;
        @(posedge clk);
        #1;
    endtask

    task start_pulse();
        ctl_start = 1'b1;
        tick();
        ctl_start = 1'b0;
    endtask

    task run_until_idle(input bit rnd, output int k);
        k = 0;
        while ((sts_run || sto_tvalid) && k < 300) begin
            if (rnd) sto_tready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("idle_timeout", 32'(k < 300), 1);
        sto_tready = 1'b1;
    endtask

    // Edges after the RUN-entry edge until tvalid is visible.
    task measure_latency(output int lat);
        lat = 0;
        while (!sto_tvalid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task check_seq(input string tag, input int len, input int reps);
        int n;
        n = reps * (len + 1);
        chk({tag, "_cnt"}, q_dat.size(), n);
        for (int i = 0; i < q_dat.size() && i < n; i++) begin
            chk($sformatf("%s_d%0d", tag, i), q_dat[i], pat[i % (len + 1)]);
            chk($sformatf("%s_l%0d", tag, i), q_lst[i], (i == n - 1) ? 1 : 0);
        end
        q_dat.delete();
        q_lst.delete();
    endtask

    initial begin
        int k;
        int lat;
        int n_early;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", sto_tvalid, 0);
        chk("rst_tlast", sto_tlast, 0);
        chk("rst_tdata", sto_tdata, 0);
        chk("rst_run", sts_run, 0);
        chk("rst_rep", sts_rep, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            mem_wen  = 1'b1;
            mem_wadr = AW'(i);
            mem_wdat = (i < 4) ? pat[i] : 8'h55;
            tick();
        end
        mem_wen = 1'b0;

        // Finite run, full throughput.
        cfg_trg = 1'b0; cfg_rep = CW'(2); cfg_len = AW'(3);
        start_pulse();
        measure_latency(lat);
        chk("t1_latency", lat, 2);
        run_until_idle(1'b0, k);
        chk("t1_cycles", k, 8);
        check_seq("t1", 3, 2);
        chk("t1_rep", sts_rep, 2);
        chk("t1_run", sts_run, 0);

        // Random backpressure.
        n_unstable = 0;
        start_pulse();
        run_until_idle(1'b1, k);
        check_seq("t2", 3, 2);
        chk("t2_stable", n_unstable, 0);
        chk("t2_rep", sts_rep, 2);

        // Trigger.
        cfg_trg = 1'b1; cfg_rep = CW'(1);
        start_pulse();
        n_early = 0;
        for (int i = 0; i < 10; i++) begin
            if (sto_tvalid) n_early++;
            tick();
        end
        chk("t3_armed", sts_run, 1);
        chk("t3_early", n_early, 0);
        trg = 1'b1;
        tick();
        trg = 1'b0;
        measure_latency(lat);
        chk("t3_latency", lat, 2);
        run_until_idle(1'b0, k);
        check_seq("t3", 3, 1);
        trg = 1'b1;
        tick();
        trg = 1'b0;
        tick();
        chk("t3_trg_idle", sts_run, 0);

        // Infinite run, stop while address 1 is read.
        cfg_trg = 1'b0; cfg_rep = CW'(0);
        start_pulse();
        tick();
        ctl_stop = 1'b1;
        tick();
        ctl_stop = 1'b0;
        run_until_idle(1'b0, k);
        check_seq("t4", 3, 1);
        chk("t4_rep", sts_rep, 1);

        // Stop coinciding with the natural final read: one tlast.
        cfg_rep = CW'(1);
        start_pulse();
        repeat (3) tick();
        ctl_stop = 1'b1;
        tick();
        ctl_stop = 1'b0;
        run_until_idle(1'b0, k);
        check_seq("t5", 3, 1);

        // Single-sample period.
        cfg_len = AW'(0); cfg_rep = CW'(3);
        start_pulse();
        run_until_idle(1'b0, k);
        check_seq("t6", 0, 3);
        chk("t6_rep", sts_rep, 3);
        cfg_len = AW'(3);

        // Abort during a stalled transfer.
        cfg_rep = CW'(0);
        start_pulse();
        repeat (10) tick();
        chk("t7_rep", sts_rep, 2);
        start_pulse();
        chk("t7_start_ignored", sts_rep, 2);
        sto_tready = 1'b0;
        repeat (3) tick();
        chk("t7_stalled", sto_tvalid, 1);
        ctl_rst = 1'b1;
        tick();
        ctl_rst = 1'b0;
        chk("t7_tvalid", sto_tvalid, 0);
        chk("t7_tlast", sto_tlast, 0);
        chk("t7_run", sts_run, 0);
        chk("t7_rep0", sts_rep, 0);
        sto_tready = 1'b1;
        q_dat.delete();
        q_lst.delete();
        cfg_rep = CW'(1);
        start_pulse();
        run_until_idle(1'b0, k);
        check_seq("t7r", 3, 1);

        // Async reset between edges.
        cfg_rep = CW'(0);
        start_pulse();
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t8_tvalid", sto_tvalid, 0);
        chk("t8_tdata", sto_tdata, 0);
        chk("t8_tlast", sto_tlast, 0);
        chk("t8_run", sts_run, 0);
        chk("t8_rep", sts_rep, 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        stall_p = 1'b0;
        repeat (2) tick();
        chk("t8_idle", sts_run, 0);
        chk("t8_idle_tvalid", sto_tvalid, 0);
        q_dat.delete();
        q_lst.delete();
        cfg_rep = CW'(1);
        start_pulse();
        run_until_idle(1'b0, k);
        check_seq("t8", 3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/la_gen.md
LA_GEN -- requirements
Module: la_gen

Interface
REQ-001 Parameter DW, default 8: sample width, one bit per logic channel.
REQ-002 Parameter AW, default 14: pattern memory address width, giving depth 2^AW samples.
REQ-003 Parameter CW, default 16: repetition counter width.
REQ-004 Ports SHALL be, in this order:
- clk, input, 1: the single clock for all logic.
- rst, input, 1: asynchronous, active-high reset.
- ctl_rst, input, 1: synchronous abort; clears state.
- ctl_start, input, 1: arm the generator.
- ctl_stop, input, 1: graceful stop.
- trg, input, 1: trigger, e.g. from LA trigger detection.
- cfg_trg, input, 1: 1 = wait for trg after arming; 0 = start immediately.
- cfg_len, input, AW: last sample address (period = cfg_len+1 samples).
- cfg_rep, input, CW: repetitions; 0 = infinite.
- mem_wen, input, 1: pattern memory write enable.
- mem_wadr, input, AW: pattern memory write address.
- mem_wdat, input, DW: pattern memory write data.
- sts_run, output, 1: generator armed or running.
- sts_rep, output, CW: completed repetitions.
- sto_tdata, output, DW: stream data.
- sto_tkeep, output, 1: always 1 while TVALID.
- sto_tlast, output, 1: marks the final sample of the stream.
- sto_tvalid, output, 1: stream valid.
- sto_tready, input, 1: stream ready.

Function
REQ-005 The FSM SHALL have the states IDLE, ARMED, RUN and STOP.
REQ-006 IDLE SHALL go to ARMED on ctl_start when cfg_trg=1, and to RUN on ctl_start when cfg_trg=0.
REQ-007 ARMED SHALL go to RUN on the first cycle with trg=1; trg is ignored in every other state.
REQ-008 RUN SHALL issue one memory read per advance cycle, where advance = (output stage empty or sto_tready=1), with the address counting 0..cfg_len and then wrapping to 0.
REQ-009 At each wrap the block SHALL increment sts_rep, saturating at the maximum count.
REQ-010 When cfg_rep≠0 and the read at address cfg_len completes repetition cfg_rep, the FSM SHALL go to STOP.
REQ-011 The sample read by that final read SHALL carry tlast=1.
REQ-012 ctl_stop in RUN SHALL finish the current repetition: the read at address cfg_len carries tlast=1, then the FSM goes to STOP.
REQ-013 STOP SHALL issue no further reads, drain the pipeline, then go to IDLE once the tlast sample has been accepted.
REQ-014 The pipeline SHALL have two stages: a synchronous memory read stage and an output register stage, both advancing only on advance.
REQ-015 Latency from RUN entry to the first sto_tvalid SHALL be 2 cycles.
REQ-016 With sto_tready held high, throughput SHALL be 1 sample/cycle.
REQ-017 Once asserted, sto_tvalid, sto_tdata and sto_tlast SHALL stay stable until the transfer (tvalid and tready) occurs.
REQ-018 ctl_rst SHALL return the FSM to IDLE, clear sts_rep, tvalid and tlast, and discard the pipeline; it has priority over every other input and is the only permitted TVALID drop without a handshake.
REQ-019 ctl_start SHALL be ignored outside IDLE; ctl_stop SHALL be ignored outside RUN.
REQ-020 ctl_start SHALL clear sts_rep.
REQ-021 When ctl_stop and the natural final read fall in the same cycle, exactly one tlast SHALL result.
REQ-022 With cfg_len=0, the block SHALL repeat address 0 every sample.
REQ-023 Memory writes SHALL be accepted in every state; a write to the address being read in the same cycle SHALL return the old data.
REQ-024 sts_run SHALL equal (state is ARMED or RUN or STOP).
REQ-025 cfg_* SHALL be sampled continuously; changing them outside IDLE is undefined.

Reset
REQ-026 On rst, the FSM SHALL enter IDLE and the address and sts_rep SHALL be 0.
REQ-027 On rst, sto_tvalid, sto_tlast and sto_tdata SHALL be 0, and sts_run SHALL be 0.
REQ-028 Pattern memory contents SHALL NOT be reset.

Structure
REQ-029 The FSM state enumeration SHALL live in a shared package la_pkg, alongside the default DW/AW/CW constants.
REQ-030 The pattern memory SHALL be a sub-module la_gen_mem: simple dual-port, one write port, one synchronous read port with read enable.

Verification
REQ-031 Finite run: memory 0..3 = 0x11,0x22,0x33,0x44, cfg_len=3, cfg_rep=2, cfg_trg=0, tready=1, ctl_start -> sequence 11 22 33 44 11 22 33 44; tlast only on the second 0x44; sts_rep=2; back to IDLE.
REQ-032 Backpressure: same as REQ-031 with tready toggled pseudo-randomly -> identical sequence, no drop or duplicate, data stable while stalled.
REQ-033 Trigger: cfg_trg=1, ctl_start, trg pulse 10 cycles later -> no tvalid before trg; first tvalid exactly 2 cycles after trg.
REQ-034 Infinite with stop: cfg_rep=0, cfg_len=3, ctl_stop asserted while address 1 is being read -> stream ends at 0x44 with tlast=1.
REQ-035 Abort: ctl_rst during a stalled transfer -> tvalid=0 the next cycle, IDLE, sts_rep=0; a following ctl_start restarts at 0x11.
REQ-036 Asynchronous reset: rst asserted mid-run between clock edges -> outputs immediately 0; after release the block is in IDLE and memory is intact.
